// File: rtl/i2s_tx_aud_pkg.sv
// i2s_tx_aud_pkg
// Shared types and helpers for the I2S TX audio stream scheduler.
//   AUD_DATA_W / AUD_TID_W / AUD_MAX_CH : beat data width, channel-id width,
//                                         maximum number of sample sources
//   aud_beat_t                          : one output beat (sample + channel id)
//   next_enabled(mask, idx)             : next set index strictly after idx,
//                                         wrapping; returns idx if no other bit set
package i2s_tx_aud_pkg;

  localparam int AUD_DATA_W = 32;
  localparam int AUD_TID_W  = 3;
  localparam int AUD_MAX_CH = 8;

  typedef struct packed {
    logic [AUD_DATA_W-1:0] data;
    logic [AUD_TID_W-1:0]  tid;
  } aud_beat_t;

  // The 3-bit add wraps modulo AUD_MAX_CH on its own. Callers pad unused
  // channels with zeros, so wrapping over 8 equals wrapping over NUM_CH.
  function automatic logic [AUD_TID_W-1:0] next_enabled(
    input logic [AUD_MAX_CH-1:0] mask,
    input logic [AUD_TID_W-1:0]  idx
  );
    logic [AUD_TID_W-1:0] res;
    logic [AUD_TID_W-1:0] cand;
    res = idx;
    for (int k = AUD_MAX_CH - 1; k >= 1; k--) begin
      cand = idx + AUD_TID_W'(k);
      if (mask[cand]) res = cand;
    end
    return res;
  endfunction

endpackage

// File: rtl/i2s_tx_rr_pick.sv
// i2s_tx_rr_pick
// Combinational search for the first set bit of mask at or after start,
// wrapping modulo N.
//   mask  : candidate bits
//   start : search origin (must be < N)
//   idx   : index of first set bit found (0 when none)
//   found : at least one bit of mask is set
module i2s_tx_rr_pick #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int c;

  // Walk from the farthest offset down to offset 0 so that the nearest
  // set bit is the last one assigned and therefore wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(start) + k;
      if (c >= N) c = c - N;
      if (mask[c]) begin
        idx   = IDX_W'(c);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_aud_stream_sched.sv
// i2s_tx_aud_stream_sched
// Merges up to NUM_CH per-channel sample streams onto one registered
// AXI-Stream audio port, in strict channel order or round-robin.
//   s_axis_aud_aclk / s_axis_aud_aresetn : clock, async active-low reset
//   req_tvalid / req_tdata / req_tready  : per-channel sample sources
//   ch_enable                            : quasi-static channel enable mask
//   ordered_mode                         : 1 = strict sequence, 0 = round-robin
//   s_axis_aud_tdata/tid/tvalid/tready   : merged output stream
//   frame_done                           : pulse after the highest enabled
//                                          channel's beat is accepted
module i2s_tx_aud_stream_sched
  import i2s_tx_aud_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32
) (
  input  logic                     s_axis_aud_aclk,
  input  logic                     s_axis_aud_aresetn,
  input  logic [NUM_CH-1:0]        req_tvalid,
  input  logic [NUM_CH*DATA_W-1:0] req_tdata,
  output logic [NUM_CH-1:0]        req_tready,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     ordered_mode,
  output logic [DATA_W-1:0]        s_axis_aud_tdata,
  output logic [2:0]               s_axis_aud_tid,
  output logic                     s_axis_aud_tvalid,
  input  logic                     s_axis_aud_tready,
  output logic                     frame_done
);

  localparam logic [AUD_TID_W-1:0] LAST_IDX = AUD_TID_W'(NUM_CH - 1);

  aud_beat_t              beat_q, beat_d;
  logic                   tvalid_q, tvalid_d;
  logic                   frame_done_q, frame_done_d;
  logic [AUD_TID_W-1:0]   ptr_q, ptr_d;
  logic                   run_q;

  logic [NUM_CH-1:0]      elig;
  logic                   load;
  logic [AUD_TID_W-1:0]   rr_idx, en_idx, win_idx, hi_idx;
  logic                   rr_found, en_found, win_ok, grant_ok;
  logic [AUD_MAX_CH-1:0]  en_pad;
  logic [DATA_W-1:0]      win_data;

  assign elig = req_tvalid & ch_enable;
  assign load = !tvalid_q || s_axis_aud_tready;

  // Round-robin winner search over eligible channels.
  i2s_tx_rr_pick #(.N(NUM_CH), .IDX_W(AUD_TID_W)) u_pick_elig (
    .mask  (elig),
    .start (ptr_q),
    .idx   (rr_idx),
    .found (rr_found)
  );

  // Ordered-mode pointer skip over disabled channels.
  i2s_tx_rr_pick #(.N(NUM_CH), .IDX_W(AUD_TID_W)) u_pick_en (
    .mask  (ch_enable),
    .start (ptr_q),
    .idx   (en_idx),
    .found (en_found)
  );

  // Winner selection, grant and pointer update. run_q holds off grants for
  // the first edge after reset release.
  always_comb begin
    en_pad             = '0;
    en_pad[NUM_CH-1:0] = ch_enable;
    win_ok             = 1'b0;
    win_idx            = ptr_q;
    ptr_d              = ptr_q;
    if (ordered_mode) begin
      if (en_found) begin
        if (!ch_enable[ptr_q]) begin
          ptr_d = en_idx;
        end else if (elig[ptr_q]) begin
          win_ok  = 1'b1;
          win_idx = ptr_q;
        end
      end
    end else if (rr_found) begin
      win_ok  = 1'b1;
      win_idx = rr_idx;
    end
    grant_ok = load && win_ok && run_q;
    if (grant_ok) begin
      if (ordered_mode) ptr_d = next_enabled(en_pad, win_idx);
      else              ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    end
  end

  // Ready fan-out and data mux, kept free of any dependence on req_tdata
  // for the ready path.
  always_comb begin
    req_tready = '0;
    win_data   = '0;
    hi_idx     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      req_tready[c] = grant_ok && (win_idx == AUD_TID_W'(c));
      if (win_idx == AUD_TID_W'(c)) win_data = req_tdata[c*DATA_W +: DATA_W];
      if (ch_enable[c]) hi_idx = AUD_TID_W'(c);
    end
  end

  // Output register: reload whenever empty or being accepted; hold otherwise.
  always_comb begin
    tvalid_d = tvalid_q;
    beat_d   = beat_q;
    if (load) begin
      if (grant_ok) begin
        tvalid_d    = 1'b1;
        beat_d.data = win_data;
        beat_d.tid  = win_idx;
      end else begin
        tvalid_d = 1'b0;
      end
    end
    frame_done_d = tvalid_q && s_axis_aud_tready && (|ch_enable) && (beat_q.tid == hi_idx);
  end

  always_ff @(posedge s_axis_aud_aclk or negedge s_axis_aud_aresetn) begin
    if (!s_axis_aud_aresetn) begin
      tvalid_q     <= 1'b0;
      beat_q       <= '0;
      frame_done_q <= 1'b0;
      ptr_q        <= '0;
      run_q        <= 1'b0;
    end else begin
      tvalid_q     <= tvalid_d;
      beat_q       <= beat_d;
      frame_done_q <= frame_done_d;
      ptr_q        <= ptr_d;
      run_q        <= 1'b1;
    end
  end

  assign s_axis_aud_tvalid = tvalid_q;
  assign s_axis_aud_tdata  = beat_q.data;
  assign s_axis_aud_tid    = beat_q.tid;
  assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_i2s_tx_aud_stream_sched.sv
// tb_i2s_tx_aud_stream_sched
// Randomized scoreboard bench. A reference model (modulo-arithmetic channel
// scheduler) predicts each grant and pushes the expected beat; a separate
// monitor pops and compares whenever the DUT presents a beat.
module tb_i2s_tx_aud_stream_sched;

  localparam int N  = 8;
  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  tid;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_tvalid = '0;
  logic [N*DW-1:0] req_tdata = '0;
  logic [N-1:0]    req_tready;
  logic [N-1:0]    ch_enable = '0;
  logic            ordered_mode = 1'b0;
  logic [DW-1:0]   s_axis_aud_tdata;
  logic [2:0]      s_axis_aud_tid;
  logic            s_axis_aud_tvalid;
  logic            s_axis_aud_tready = 1'b0;
  logic            frame_done;

  exp_t            sb[$];
  int              vectors = 0;
  int              miscompares = 0;
  int              ptr_m = 0;
  bit              run_m = 1'b0;
  bit              exp_fd = 1'b0;
  int              granted_ch = -1;
  logic [N-1:0]    v_r = '0;
  logic [31:0]     d_r[N];

  i2s_tx_aud_stream_sched #(.NUM_CH(N), .DATA_W(DW)) dut (
    .s_axis_aud_aclk    (clk),
    .s_axis_aud_aresetn (rst_n),
    .req_tvalid         (req_tvalid),
    .req_tdata          (req_tdata),
    .req_tready         (req_tready),
    .ch_enable          (ch_enable),
    .ordered_mode       (ordered_mode),
    .s_axis_aud_tdata   (s_axis_aud_tdata),
    .s_axis_aud_tid     (s_axis_aud_tid),
    .s_axis_aud_tvalid  (s_axis_aud_tvalid),
    .s_axis_aud_tready  (s_axis_aud_tready),
    .frame_done         (frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int highestEn(input logic [N-1:0] en);
    int h = -1;
    for (int c = 0; c < N; c++) if (en[c]) h = c;
    return h;
  endfunction

  function automatic int nextEn(input logic [N-1:0] en, input int p);
    for (int k = 1; k <= N; k++) if (en[(p + k) % N]) return (p + k) % N;
    return p;
  endfunction

  // Drive one phase of random requester traffic; a valid sample is held
  // until the model says it was granted.
  task automatic applyStimulus(input logic [N-1:0] en, input bit ord,
                               input int valid_pct, input int ready_pct, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
        if (!v_r[c] || granted_ch == c) begin
          v_r[c] = ($urandom_range(99) < valid_pct);
          d_r[c] = $urandom;
        end
        req_tdata[c*DW +: DW] = d_r[c];
      end
      req_tvalid        = v_r;
      ch_enable         = en;
      ordered_mode      = ord;
      s_axis_aud_tready = ($urandom_range(99) < ready_pct);
    end
  endtask

  // Reset in the middle of a cycle, check the asynchronous clear at once.
  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_tvalid", s_axis_aud_tvalid, 1'b0);
    checkOutput("async_rst_tdata", s_axis_aud_tdata, 32'h0);
    checkOutput("async_rst_tid", s_axis_aud_tid, 3'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare the presented beat with the scoreboard head, pop on
  // downstream handshake, and predict frame_done for the next cycle.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (!rst_n) begin
        sb.delete();
        exp_fd = 1'b0;
        checkOutput("rst_tvalid", s_axis_aud_tvalid, 1'b0);
        checkOutput("rst_frame_done", frame_done, 1'b0);
      end else begin
        checkOutput("frame_done", frame_done, exp_fd);
        if (sb.size() > 0) begin
          checkOutput("tvalid", s_axis_aud_tvalid, 1'b1);
          checkOutput("tdata", s_axis_aud_tdata, sb[0].data);
          checkOutput("tid", s_axis_aud_tid, sb[0].tid);
        end else begin
          checkOutput("tvalid_idle", s_axis_aud_tvalid, 1'b0);
        end
        exp_fd = 1'b0;
        if (sb.size() > 0 && s_axis_aud_tready) begin
          exp_fd = (ch_enable != 0) && (int'(sb[0].tid) == highestEn(ch_enable));
          void'(sb.pop_front());
        end
      end
    end
  end

  // Reference model: the output slot is free this cycle exactly when the
  // scoreboard is empty after the monitor's pop.
  initial begin
    logic [N-1:0] elig;
    logic [N-1:0] exp_rdy;
    bit           slot_free;
    int           w;
    forever begin
      @(posedge clk);
      #4;
      w = -1;
      if (!rst_n) begin
        ptr_m = 0;
        run_m = 1'b0;
      end else begin
        elig      = req_tvalid & ch_enable;
        slot_free = (sb.size() == 0);
        if (run_m) begin
          if (ordered_mode) begin
            if (ch_enable != 0) begin
              if (!ch_enable[ptr_m]) ptr_m = nextEn(ch_enable, ptr_m);
              else if (elig[ptr_m] && slot_free) w = ptr_m;
            end
          end else if (slot_free) begin
            for (int k = 0; k < N; k++) begin
              if (w < 0 && elig[(ptr_m + k) % N]) w = (ptr_m + k) % N;
            end
          end
        end
        if (w >= 0) begin
          sb.push_back('{data: d_r[w], tid: 3'(w)});
          ptr_m = ordered_mode ? nextEn(ch_enable, w) : (w + 1) % N;
        end
        run_m = 1'b1;
      end
      exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
      checkOutput("req_tready", req_tready, exp_rdy);
      granted_ch = w;
    end
  end

  initial begin
    for (int c = 0; c < N; c++) d_r[c] = '0;
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'hFF, 1'b0, 100, 100, 20);
    applyStimulus(8'hFF, 1'b0, 60, 70, 150);
    applyStimulus(8'h0F, 1'b1, 50, 80, 150);
    applyStimulus(8'h22, 1'b1, 70, 80, 80);
    applyStimulus(8'hFF, 1'b0, 100, 100, 3);
    applyStimulus(8'hFF, 1'b0, 100, 0, 6);
    for (int p = 0; p < 10; p++) begin
      applyStimulus(N'($urandom), 1'($urandom), 65, 75, 40);
    end
    applyStimulus(8'hFF, 1'b0, 100, 0, 2);
    applyStimulus(8'h00, 1'b0, 100, 0, 3);
    applyStimulus(8'h00, 1'b0, 100, 100, 5);
    applyStimulus(8'hFF, 1'b1, 100, 0, 3);
    doReset();
    applyStimulus(8'hFF, 1'b0, 100, 100, 12);
    applyStimulus(8'hFF, 1'b0, 0, 100, 6);
    @(posedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
